stopwatch_core: RTL and testbench

Upstream timekeeping stage of the stopwatch display path. Counts 100 Hz ticks into BCD digits MM:SS.CC and handles start/stop and lap/reset push-buttons. Presents the min/sec/ces digit buses and a running flag, clocked on the 1 MHz system clock. The SPI display driver samples these buses on each 100 Hz frame.

---
 rtl/stopwatch_core_pkg.sv | 42 ++++
 rtl/button_debounce.sv | 36 +++
 rtl/stopwatch_core.sv | 49 ++++
 tb/tb_stopwatch_core.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/stopwatch_core_pkg.sv
// stopwatch_core_pkg: FSM states, digit limits, default debounce length and BCD increment
package stopwatch_core_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, LAP = 2'd2, STOP = 2'd3} state_t;
  localparam logic [3:0] CES_MAX = 4'd9;
  localparam logic [2:0] SEC_TENS_MAX = 3'd5;
  localparam int DEBOUNCE_DEFAULT = 10000;
  typedef struct packed {
    logic [2:0] min_t;
    logic [3:0] min_u;
    logic [2:0] sec_t;
    logic [3:0] sec_u;
    logic [3:0] ces_t;
    logic [3:0] ces_u;
  } digits_t;
  // MM:SS.CC + 1 with ripple carry; 59:59.99 wraps to 00:00.00
  function automatic digits_t bcd_inc(input digits_t c);
    digits_t t;
    t = c;
    if (c.ces_u != CES_MAX) t.ces_u = c.ces_u + 4'd1;
    else begin
      t.ces_u = '0;
      if (c.ces_t != CES_MAX) t.ces_t = c.ces_t + 4'd1;
      else begin
        t.ces_t = '0;
        if (c.sec_u != CES_MAX) t.sec_u = c.sec_u + 4'd1;
        else begin
          t.sec_u = '0;
          if (c.sec_t != SEC_TENS_MAX) t.sec_t = c.sec_t + 3'd1;
          else begin
            t.sec_t = '0;
            if (c.min_u != CES_MAX) t.min_u = c.min_u + 4'd1;
            else begin
              t.min_u = '0;
              t.min_t = (c.min_t != SEC_TENS_MAX) ? c.min_t + 3'd1 : 3'd0;
            end
          end
        end
      end
    end
    return t;
  endfunction
endpackage

// File: rtl/button_debounce.sv
// button_debounce: 2-FF synchroniser plus stability counter, one press pulse per held press
//   clk, res (async active-low), btn (raw button), press (1-cycle pulse)
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic res,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2, fired;
  logic [CW-1:0] cnt;
  logic done;
  assign done = cnt == CW'(DEBOUNCE_CYCLES - 1);
  // fired blocks further pulses until the synced level drops
  always_ff @(posedge clk or negedge res)
    if (!res) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      fired <= 1'b0;
      press <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      press <= s2 && !fired && done;
      if (!s2) begin
        cnt <= '0;
        fired <= 1'b0;
      end else if (!fired) begin
        if (done) fired <= 1'b1;
        else cnt <= cnt + CW'(1);
      end
    end
endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: 100 Hz tick counter into BCD MM:SS.CC with start/stop and lap/reset buttons
//   clk (1 MHz), res (async active-low), ena (freeze when low), clk_div (100 Hz, async),
//   btn_ss / btn_lr (raw buttons), min/sec/ces digit outputs (registered), running (RUN or LAP)
module stopwatch_core
  import stopwatch_core_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       clk,
  input  logic       res,
  input  logic       ena,
  input  logic       clk_div,
  input  logic       btn_ss,
  input  logic       btn_lr,
  output logic [2:0] min_X0,
  output logic [3:0] min_0X,
  output logic [2:0] sec_X0,
  output logic [3:0] sec_0X,
  output logic [3:0] ces_X0,
  output logic [3:0] ces_0X,
  output logic       running
);
  logic cd1, cd2, cd_d, tick, ss_p, lr_p, ss, lr, live;
  state_t state;
  digits_t cnt, disp;
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ss (.clk(clk), .res(res), .btn(btn_ss), .press(ss_p));
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lr (.clk(clk), .res(res), .btn(btn_lr), .press(lr_p));
  always_ff @(posedge clk or negedge res)
    if (!res) {cd1, cd2, cd_d} <= 3'b000;
    else {cd1, cd2, cd_d} <= {clk_div, cd1, cd2};
  assign tick = cd2 & ~cd_d;
  // ss wins over a coincident lr
  assign ss = ena & ss_p;
  assign lr = ena & lr_p & ~ss_p;
  assign live = state == RUN || state == LAP;
  always_ff @(posedge clk or negedge res)
    if (!res) begin
      state <= IDLE;
      cnt <= '0;
      disp <= '0;
      running <= 1'b0;
    end else if (ena) begin
      running <= live;
      disp <= state == LAP ? disp : cnt;
      cnt <= (state == STOP && lr) ? '0 : (tick && live) ? bcd_inc(cnt) : cnt;
      state <= ss ? (live ? STOP : RUN) : lr ? (state == RUN ? LAP : state == LAP ? RUN : IDLE) : state;
    end
  assign {min_X0, min_0X, sec_X0, sec_0X, ces_X0, ces_0X} = disp;
endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: directed self-checking bench for stopwatch_core
module tb_stopwatch_core;
  logic clk = 1'b0, res = 1'b0, ena = 1'b1, clk_div = 1'b0, btn_ss = 1'b0, btn_lr = 1'b0;
  logic [2:0] min_X0, sec_X0;
  logic [3:0] min_0X, sec_0X, ces_X0, ces_0X;
  logic running;
  logic [21:0] disp;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  stopwatch_core #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .res(res), .ena(ena), .clk_div(clk_div), .btn_ss(btn_ss), .btn_lr(btn_lr),
    .min_X0(min_X0), .min_0X(min_0X), .sec_X0(sec_X0), .sec_0X(sec_0X),
    .ces_X0(ces_X0), .ces_0X(ces_0X), .running(running)
  );
  assign disp = {min_X0, min_0X, sec_X0, sec_0X, ces_X0, ces_0X};
  function automatic logic [21:0] bcd(input int m, input int s, input int c);
    return {3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction
  function automatic string fmt(input logic [21:0] v);
    return $sformatf("%0d%0d:%0d%0d.%0d%0d", v[21:19], v[18:15], v[14:12], v[11:8], v[7:4], v[3:0]);
  endfunction
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) clk_div = 1'b1;
      @(negedge clk);
      @(negedge clk) clk_div = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
  endtask
  task automatic press(input logic s, input logic l);
    @(negedge clk);
    btn_ss = s;
    btn_lr = l;
    repeat (8) @(negedge clk);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    repeat (6) @(negedge clk);
  endtask
  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (disp !== bcd(0, 0, 0)) begin errors++; $display("FAIL reset_disp got %s exp %s", fmt(disp), fmt(bcd(0, 0, 0))); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp 0", running); end
    res = 1'b1;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_count;
    press(1'b1, 1'b0);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running got %b exp 1", running); end
    ticks(100);
    checks++; if (disp !== bcd(0, 1, 0)) begin errors++; $display("FAIL count_100 got %s exp %s", fmt(disp), fmt(bcd(0, 1, 0))); end
    ticks(6000);
    checks++; if (disp !== bcd(1, 1, 0)) begin errors++; $display("FAIL count_6100 got %s exp %s", fmt(disp), fmt(bcd(1, 1, 0))); end
  endtask
  task automatic test_wrap;
    @(negedge clk) force dut.cnt = 22'h2CD999;
    @(negedge clk) release dut.cnt;
    @(negedge clk);
    checks++; if (disp !== bcd(59, 59, 99)) begin errors++; $display("FAIL preload got %s exp %s", fmt(disp), fmt(bcd(59, 59, 99))); end
    ticks(1);
    checks++; if (disp !== bcd(0, 0, 0)) begin errors++; $display("FAIL wrap got %s exp %s", fmt(disp), fmt(bcd(0, 0, 0))); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL wrap_running got %b exp 1", running); end
  endtask
  task automatic test_lap;
    ticks(250);
    press(1'b0, 1'b1);
    checks++; if (disp !== bcd(0, 2, 50)) begin errors++; $display("FAIL lap_entry got %s exp %s", fmt(disp), fmt(bcd(0, 2, 50))); end
    ticks(30);
    checks++; if (disp !== bcd(0, 2, 50)) begin errors++; $display("FAIL lap_hold got %s exp %s", fmt(disp), fmt(bcd(0, 2, 50))); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL lap_running got %b exp 1", running); end
    press(1'b0, 1'b1);
    checks++; if (disp !== bcd(0, 2, 80)) begin errors++; $display("FAIL lap_release got %s exp %s", fmt(disp), fmt(bcd(0, 2, 80))); end
  endtask
  task automatic test_stop_clear;
    ticks(20);
    checks++; if (disp !== bcd(0, 3, 0)) begin errors++; $display("FAIL pre_stop got %s exp %s", fmt(disp), fmt(bcd(0, 3, 0))); end
    press(1'b1, 1'b0);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL stop_running got %b exp 0", running); end
    ticks(10);
    checks++; if (disp !== bcd(0, 3, 0)) begin errors++; $display("FAIL stop_hold got %s exp %s", fmt(disp), fmt(bcd(0, 3, 0))); end
    press(1'b0, 1'b1);
    checks++; if (disp !== bcd(0, 0, 0)) begin errors++; $display("FAIL clear got %s exp %s", fmt(disp), fmt(bcd(0, 0, 0))); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL clear_running got %b exp 0", running); end
    press(1'b0, 1'b1);
    ticks(1);
    checks++; if (disp !== bcd(0, 0, 0)) begin errors++; $display("FAIL idle_lr got %s exp %s", fmt(disp), fmt(bcd(0, 0, 0))); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL idle_lr_running got %b exp 0", running); end
  endtask
  task automatic test_debounce;
    @(negedge clk) btn_ss = 1'b1;
    repeat (3) @(negedge clk);
    btn_ss = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL short_glitch_running got %b exp 0", running); end
    ticks(1);
    checks++; if (disp !== bcd(0, 0, 0)) begin errors++; $display("FAIL short_glitch_count got %s exp %s", fmt(disp), fmt(bcd(0, 0, 0))); end
    @(negedge clk) btn_ss = 1'b1;
    repeat (4) @(negedge clk);
    btn_ss = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL exact_press_running got %b exp 1", running); end
    ticks(1);
    checks++; if (disp !== bcd(0, 0, 1)) begin errors++; $display("FAIL exact_press_count got %s exp %s", fmt(disp), fmt(bcd(0, 0, 1))); end
  endtask
  task automatic test_coincide;
    press(1'b1, 1'b1);
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL coincide_running got %b exp 0", running); end
    ticks(1);
    checks++; if (disp !== bcd(0, 0, 1)) begin errors++; $display("FAIL coincide_count got %s exp %s", fmt(disp), fmt(bcd(0, 0, 1))); end
    press(1'b1, 1'b0);
  endtask
  task automatic test_ena;
    @(negedge clk) ena = 1'b0;
    ticks(10);
    checks++; if (disp !== bcd(0, 0, 1)) begin errors++; $display("FAIL ena_ticks got %s exp %s", fmt(disp), fmt(bcd(0, 0, 1))); end
    press(1'b1, 1'b0);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL ena_press got %b exp 1", running); end
    @(negedge clk) btn_ss = 1'b1;
    repeat (8) @(negedge clk);
    ena = 1'b1;
    repeat (8) @(negedge clk);
    btn_ss = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL ena_held_button got %b exp 1", running); end
    ticks(10);
    checks++; if (disp !== bcd(0, 0, 11)) begin errors++; $display("FAIL ena_resume got %s exp %s", fmt(disp), fmt(bcd(0, 0, 11))); end
  endtask
  task automatic test_async_reset;
    ticks(5);
    @(negedge clk);
    #2 res = 1'b0;
    #1;
    checks++; if (disp !== bcd(0, 0, 0)) begin errors++; $display("FAIL async_reset_disp got %s exp %s", fmt(disp), fmt(bcd(0, 0, 0))); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL async_reset_running got %b exp 0", running); end
    @(negedge clk) res = 1'b1;
    ticks(3);
    checks++; if (disp !== bcd(0, 0, 0)) begin errors++; $display("FAIL post_reset_idle got %s exp %s", fmt(disp), fmt(bcd(0, 0, 0))); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL post_reset_running got %b exp 0", running); end
  endtask
  initial begin
    test_reset;
    test_count;
    test_wrap;
    test_lap;
    test_stop_clear;
    test_debounce;
    test_coincide;
    test_ena;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
